// File: rtl/instr_loader.sv
// instr_loader: debounced two-half instruction entry into a FIFO, popped by fetch in run mode.
module instr_loader #(
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_n,
    input  logic [17:0]              SW,
    input  logic                     rd_en,
    output logic [3:0]               codop,
    output logic [7:0]               addA,
    output logic [7:0]               addB_LMM,
    output logic [7:0]               addC,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     hi_pending,
    output logic                     overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {WAIT_HI, WAIT_LO} state_t;

    logic          r_sync1, r_sync2, r_key_db;
    logic [CW-1:0] r_db_cnt;
    logic          w_db_done, w_press;
    state_t        r_state, w_state_nxt;
    logic          w_latch_hi, w_commit, w_wr, w_rd;
    logic [11:0]   r_hi;
    logic [27:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_unused;

    assign w_unused  = SW[16];
    assign w_db_done = (r_sync2 != r_key_db) && (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1));
    // Strobe on the cycle the debounced level is about to fall; the release edge gives nothing.
    assign w_press   = w_db_done & r_key_db & ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_key_db <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (w_db_done) begin
                r_key_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_hi  = 1'b0;
        w_commit    = 1'b0;
        if (SW[17]) begin
            w_state_nxt = WAIT_HI;
        end else if (w_press) begin
            w_latch_hi  = (r_state == WAIT_HI);
            w_commit    = (r_state == WAIT_LO);
            w_state_nxt = (r_state == WAIT_HI) ? WAIT_LO : WAIT_HI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HI;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_hi) r_hi <= SW[11:0];
        end
    end

    assign w_wr = w_commit & ~full;
    assign w_rd = rd_en & SW[17] & ~empty;

    // Storage is left uninitialised; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_hi, SW[15:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            overflow_err <= 1'b0;
            instr_valid  <= 1'b0;
            codop        <= '0;
            addA         <= '0;
            addB_LMM     <= '0;
            addC         <= '0;
        end else begin
            instr_valid <= w_rd;
            if (w_commit & full) overflow_err <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
                {codop, addA, addB_LMM, addC} <= r_mem[r_rd_ptr];
            end
        end
    end

    assign count      = r_count;
    assign full       = (r_count == (AW + 1)'(DEPTH));
    assign empty      = (r_count == '0);
    assign hi_pending = (r_state == WAIT_LO);
endmodule

// File: doc/instr_loader.md
# instr_loader

Instruction entry buffer that sits in front of the fetch stage. It is the write side of the instruction path: the operator keys each instruction in from the slide switches and a pushbutton. Each instruction is entered in two halves, and the block commits the complete 28-bit word into a 16-entry FIFO. The fetch stage later pops one instruction per request and receives the same `codop`/`addA`/`addB_LMM`/`addC` fields the switch-driven fetch supplies today.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two.
- `DEBOUNCE_CYCLES`, default 500000: number of cycles the key level must stay stable before it is accepted (10 ms at 50 MHz).
- `clk` input, 1 bit: single clock (CLOCK_50 domain).
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `key_n` input, 1 bit: raw pushbutton, active-low, asynchronous.
- `SW` input, 18 bits: `SW[17]` is the mode (0 = load, 1 = run); `SW[15:0]` is data.
- `rd_en` input, 1 bit: single-cycle pop request from fetch.
- `codop` output, 4 bits: opcode of the last popped instruction.
- `addA` output, 8 bits: field of the last popped instruction.
- `addB_LMM` output, 8 bits: field of the last popped instruction.
- `addC` output, 8 bits: field of the last popped instruction.
- `instr_valid` output, 1 bit: one-cycle pulse marking a fresh pop.
- `count` output, log2(DEPTH)+1 bits: current occupancy.
- `full` output, 1 bit: `count == DEPTH`.
- `empty` output, 1 bit: `count == 0`.
- `hi_pending` output, 1 bit: upper half captured, waiting for the lower half (drives an LED).
- `overflow_err` output, 1 bit: sticky; a commit was attempted while full.

## Operation
- **Key path.**
  - `key_n` passes through a two-flop synchronizer.
  - A debounce counter accepts a new level only after it has been stable for `DEBOUNCE_CYCLES` cycles.
  - A press event is a one-cycle strobe on the debounced 1→0 transition. Each physical press produces exactly one event; release produces none.
- **Entry FSM**, states WAIT_HI and WAIT_LO:
  - WAIT_HI, press event, `SW[17]=0`: latch `{codop, addA} = SW[11:0]`, go to WAIT_LO, set `hi_pending=1`.
  - WAIT_LO, press event, `SW[17]=0`:
    - Form the word `{hi[11:0], SW[15:0]}`, which is `{codop, addA, addB_LMM, addC}`.
    - If not full, write it at `wr_ptr`, increment `wr_ptr` (mod DEPTH) and increment `count`.
    - If full, drop the word and set `overflow_err`.
    - In both cases return to WAIT_HI and clear `hi_pending`.
  - Any state with `SW[17]=1`: the FSM is forced to WAIT_HI, any pending upper half is discarded, and press events are ignored.
- **Read path** (only when `SW[17]=1`):
  - `rd_en` while not empty: on the next edge, register `mem[rd_ptr]` onto the four field outputs, pulse `instr_valid` for one cycle, increment `rd_ptr` (mod DEPTH) and decrement `count`.
  - `rd_en` while empty, or while `SW[17]=0`: no pop, `instr_valid` stays 0 and the field outputs hold.
- **No simultaneous access.** Because writes happen only in load mode and reads only in run mode, a write and a read never occur in the same cycle.
- **Pointer wrap.** Pointers wrap modulo DEPTH. `count` is the only source for `full` and `empty`.
- **Memory contents.** Memory is not cleared by reset. The pointers and `count` define which entries are valid.

## Timing
- **Reset values.** The following are 0 and asserted immediately, asynchronously:
  - `codop`, `addA`, `addB_LMM`, `addC`
  - `instr_valid`, `count`, `full`, `hi_pending`, `overflow_err`
  - the pointers and the debounce counter
  - the debounced key level (1, i.e. released)
  - the FSM (WAIT_HI)
  - `empty` reads 1.
- **Press latency.**
  - The event fires 2 sync cycles plus `DEBOUNCE_CYCLES` cycles after `key_n` falls and stays low.
  - Bounces shorter than `DEBOUNCE_CYCLES` restart the counter and produce no event.
- **Commit.** Memory, `count`, `full` and `empty` update at the edge that samples the second press event.
- **Pop latency.**
  - Fields and `instr_valid` appear 1 cycle after `rd_en` is sampled.
  - `rd_en` held high pops once per cycle until empty.
- **Reset mid-entry.** The pending half and all queued instructions are lost. No partial write is possible.
- **`overflow_err`.** Cleared only by reset.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset.**
  - Stimulus: assert `rst_n=0` mid-cycle.
  - Required: all outputs go to the reset values immediately; `empty=1`, `count=0`.
- **Single entry and pop.**
  - Stimulus: press with `SW=0x00_3A5`, then press with `SW=0x0_1207`, then set `SW[17]=1` and pulse `rd_en`.
  - Required: after the second press `count=1`. After `rd_en`: `codop=3`, `addA=0xA5`, `addB_LMM=0x12`, `addC=0x07`, and `instr_valid` is high for exactly 1 cycle.
- **Bounce rejection.**
  - Stimulus: toggle `key_n` low and high every 2 cycles for 20 cycles, then hold it low.
  - Required: exactly one press event, and `hi_pending=1` afterwards.
- **Full and wrap.**
  - Stimulus: commit 17 words with values 0..16.
  - Required: `full=1` and `count=16`; `overflow_err=1` after the 17th. Popping 16 times returns 0..15 in order, ending with `empty=1`.
  - Follow-on: commit 3 more words and pop them; the order holds across the pointer wrap.
- **Mode switch mid-entry.**
  - Stimulus: enter the upper half, set `SW[17]=1`, then back to 0, then enter two halves.
  - Required: `hi_pending` clears at the switch. The stored word consists only of the two new halves, and `count=1`.
- **Empty read.**
  - Stimulus: `rd_en` with `empty=1`.
  - Required: `instr_valid=0`, the field outputs are unchanged, and `count` stays 0.
